// File: rtl/mi_issue_queue.sv
// Dual-issue instruction queue between fetch and the two decoders.
// Circular buffer of {inst, pc}; slot 1 issues only when slot 0 is not a
// control-flow instruction and slot 1 does not read slot 0's destination.
module mi_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int INST_DW = 32,
  parameter int INST_AW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               fetch_valid_i,
  input  logic [INST_DW-1:0]       fetch_inst0_i,
  input  logic [INST_DW-1:0]       fetch_inst1_i,
  input  logic [INST_AW-1:0]       fetch_pc_i,
  output logic                     fetch_ready_o,
  input  logic                     flush_i,
  input  logic                     id_ready_i,
  output logic                     issue0_valid_o,
  output logic                     issue1_valid_o,
  output logic [INST_DW-1:0]       issue0_inst_o,
  output logic [INST_DW-1:0]       issue1_inst_o,
  output logic [INST_AW-1:0]       issue0_pc_o,
  output logic [INST_AW-1:0]       issue1_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [INST_DW-1:0] inst_q [DEPTH];
  logic [INST_AW-1:0] pc_q   [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic [PW-1:0]      head1, tail1;
  logic [INST_DW-1:0] s0_inst, s1_inst;
  logic [6:0]         s0_op;
  logic [4:0]         s0_rd;
  logic               s0_cf, s0_wr, raw, v0, v1;
  logic [1:0]         push_n, pop_n;

  // Power-of-two depth: pointer arithmetic wraps for free.
  assign head1   = head_q + PW'(1);
  assign tail1   = tail_q + PW'(1);
  assign s0_inst = inst_q[head_q];
  assign s1_inst = inst_q[head1];
  assign s0_op   = s0_inst[6:0];
  assign s0_rd   = s0_inst[11:7];

  // Dual-issue eligibility of slot 1 and the push/pop amounts for this cycle.
  always_comb begin
    s0_cf  = (s0_op == OP_BRANCH) || (s0_op == OP_JAL) || (s0_op == OP_JALR);
    s0_wr  = (s0_op != OP_BRANCH) && (s0_op != OP_STORE);
    raw    = (s0_rd != 5'd0) && s0_wr &&
             ((s0_rd == s1_inst[19:15]) || (s0_rd == s1_inst[24:20]));
    v0     = (count_q != '0) && !flush_i;
    v1     = v0 && (count_q >= CW'(2)) && !s0_cf && !raw;
    fetch_ready_o = (count_q <= CW'(DEPTH - 2)) && !flush_i;
    push_n = 2'd0;
    if (fetch_ready_o && fetch_valid_i[0])
      push_n = fetch_valid_i[1] ? 2'd2 : 2'd1;
    pop_n  = id_ready_i ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
  end

  // Pointer/count next state; flush empties the queue and drops any fetch.
  always_comb begin
    head_d  = head_q + PW'(pop_n);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers; reset empties the queue asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!flush_i && push_n != 2'd0) begin
      inst_q[tail_q] <= fetch_inst0_i;
      pc_q[tail_q]   <= fetch_pc_i;
    end
    if (!flush_i && push_n == 2'd2) begin
      inst_q[tail1] <= fetch_inst1_i;
      pc_q[tail1]   <= fetch_pc_i + INST_AW'(4);
    end
  end

  assign issue0_valid_o = v0;
  assign issue1_valid_o = v1;
  assign issue0_inst_o  = v0 ? s0_inst : '0;
  assign issue1_inst_o  = v1 ? s1_inst : '0;
  assign issue0_pc_o    = v0 ? pc_q[head_q] : '0;
  assign issue1_pc_o    = v1 ? pc_q[head1]  : '0;
  assign count_o        = count_q;
endmodule

// File: tb/tb_mi_issue_queue.sv
module tb_mi_issue_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fv;
  logic [31:0] i0, i1, pc;
  logic        flush, idr;
  logic        rdy, v0, v1;
  logic [31:0] o_i0, o_i1, o_p0, o_p1;
  logic [3:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mi_issue_queue #(.DEPTH(DEPTH), .INST_DW(32), .INST_AW(32)) dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fv), .fetch_inst0_i(i0),
    .fetch_inst1_i(i1), .fetch_pc_i(pc), .fetch_ready_o(rdy),
    .flush_i(flush), .id_ready_i(idr), .issue0_valid_o(v0),
    .issue1_valid_o(v1), .issue0_inst_o(o_i0), .issue1_inst_o(o_i1),
    .issue0_pc_o(o_p0), .issue1_pc_o(o_p1), .count_o(cnt)
  );

  // Reference model: a plain queue of {inst, pc} in program order.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t mq[$];

  logic        e_rdy, e_v0, e_v1;
  logic [31:0] e_i0, e_i1, e_p0, e_p1;
  logic [3:0]  e_cnt;

  // Expected outputs from the model contents and the current inputs.
  task automatic predict();
    logic [6:0] op;
    logic [4:0] rd;
    bit cf, wr, haz;
    e_cnt = 4'(mq.size());
    e_rdy = (mq.size() <= DEPTH - 2) && !flush;
    e_v0  = (mq.size() >= 1) && !flush;
    e_v1  = 1'b0;
    if (e_v0 && mq.size() >= 2) begin
      op  = mq[0].inst[6:0];
      rd  = mq[0].inst[11:7];
      cf  = (op == 7'h63) || (op == 7'h6F) || (op == 7'h67);
      wr  = (op != 7'h63) && (op != 7'h23);
      haz = (rd != 0) && wr && (rd == mq[1].inst[19:15] || rd == mq[1].inst[24:20]);
      e_v1 = !cf && !haz;
    end
    e_i0 = e_v0 ? mq[0].inst : 32'd0;
    e_p0 = e_v0 ? mq[0].pc   : 32'd0;
    e_i1 = e_v1 ? mq[1].inst : 32'd0;
    e_p1 = e_v1 ? mq[1].pc   : 32'd0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic f, input logic r);
    fv = v; i0 = a; i1 = b; pc = p; flush = f; idr = r;
    #1;
  endtask

  // One clock: advance the model by the same rules, then return at the negedge.
  task automatic step();
    int npop;
    predict();
    npop = idr ? (int'(e_v0) + int'(e_v1)) : 0;
    @(posedge clk);
    if (!rst || flush) mq.delete();
    else begin
      repeat (npop) void'(mq.pop_front());
      if (e_rdy && fv[0]) begin
        mq.push_back('{i0, pc});
        if (fv[1]) mq.push_back('{i1, pc + 32'd4});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if ({v0, v1, o_i0, o_i1, o_p0, o_p1, cnt, rdy} !== {2'b00, 128'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b%b cnt=%0d rdy=%b data=%h/%h required zero outputs, rdy=1",
               v0, v1, cnt, rdy, o_i0, o_p0);
    end
    drive(2'b00, 0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flush_ready: got %b required 0", rdy);
    end
    drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; @(negedge clk);
  endtask

  task automatic test_pair_issue();
    drive(2'b11, 32'h00100093, 32'h00200113, 32'h100, 1'b0, 1'b0);
    n_checks++;
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL pair_no_same_cycle: v0=%b required 0", v0); end
    step();
    drive(2'b00, 0, 0, 0, 1'b0, 1'b1);
    n_checks++;
    if ({v0, v1, o_p0, o_p1, cnt} !== {2'b11, 32'h100, 32'h104, 4'd2}) begin
      n_fail++;
      $display("FAIL pair_issue: got v=%b%b pc=%h/%h cnt=%0d required 11 100/104 2", v0, v1, o_p0, o_p1, cnt);
    end
    step();
    n_checks++;
    if (cnt !== 4'd0) begin n_fail++; $display("FAIL pair_drain: cnt=%0d required 0", cnt); end
  endtask

  task automatic test_raw();
    drive(2'b11, 32'h00100093, 32'h00108133, 32'h200, 1'b0, 1'b0);
    step();
    drive(2'b00, 0, 0, 0, 1'b0, 1'b1);
    n_checks++;
    if ({v0, v1} !== 2'b10) begin n_fail++; $display("FAIL raw_block: v=%b%b required 10", v0, v1); end
    step();
    n_checks++;
    if ({v0, o_i0, o_p0, cnt} !== {1'b1, 32'h00108133, 32'h204, 4'd1}) begin
      n_fail++;
      $display("FAIL raw_advance: got v0=%b inst=%h pc=%h cnt=%0d required 1 00108133 204 1", v0, o_i0, o_p0, cnt);
    end
    step();
  endtask

  task automatic test_branch();
    drive(2'b11, 32'hFE0008E3, 32'h00200113, 32'h300, 1'b0, 1'b0);
    step();
    drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if ({v0, v1, o_i1, o_p1} !== {2'b10, 64'd0}) begin
      n_fail++; $display("FAIL branch_single: v=%b%b inst1=%h pc1=%h required 10 0 0", v0, v1, o_i1, o_p1);
    end
    idr = 1'b1; step(); step();
    idr = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] p = 32'h1000;
    while (mq.size() < 6) begin
      drive(2'b11, 32'h00000013, 32'h00000013, p, 1'b0, 1'b0);
      p += 8; step();
    end
    drive(2'b01, 32'h00000013, 0, p, 1'b0, 1'b0);
    p += 4; step();
    drive(2'b11, 32'h00000013, 32'h00000013, p, 1'b0, 1'b0);
    n_checks++;
    if ({rdy, cnt} !== {1'b0, 4'd7}) begin
      n_fail++; $display("FAIL full_ready: rdy=%b cnt=%0d required 0 7", rdy, cnt);
    end
    step();
    n_checks++;
    if (cnt !== 4'd7) begin n_fail++; $display("FAIL full_hold: cnt=%0d required 7", cnt); end
    // Readiness comes from the pre-pop count, so this pop frees space without a push.
    drive(2'b11, 32'h00000013, 32'h00000013, p, 1'b0, 1'b1);
    step();
    n_checks++;
    if (cnt !== 4'd5) begin n_fail++; $display("FAIL full_pop: cnt=%0d required 5", cnt); end
    repeat (4) begin
      drive(2'b11, 32'h00000013, 32'h00000013, p, 1'b0, 1'b1);
      p += 8; predict();
      n_checks++;
      if ({cnt, o_p0, o_p1} !== {e_cnt, e_p0, e_p1}) begin
        n_fail++; $display("FAIL full_wrap: cnt=%0d pc=%h/%h required %0d %h/%h", cnt, o_p0, o_p1, e_cnt, e_p0, e_p1);
      end
      step();
    end
  endtask

  task automatic test_flush();
    drive(2'b00, 0, 0, 0, 1'b1, 1'b0); step();
    drive(2'b11, 32'h13, 32'h13, 32'h2000, 1'b0, 1'b0); step();
    drive(2'b11, 32'h13, 32'h13, 32'h2008, 1'b0, 1'b0); step();
    drive(2'b01, 32'h13, 32'h13, 32'h2010, 1'b0, 1'b0); step();
    drive(2'b11, 32'h13, 32'h13, 32'h2014, 1'b1, 1'b1);
    n_checks++;
    if ({cnt, rdy, v0, v1} !== {4'd5, 3'b000}) begin
      n_fail++; $display("FAIL flush_cycle: cnt=%0d rdy=%b v=%b%b required 5 0 00", cnt, rdy, v0, v1);
    end
    step();
    drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if ({cnt, rdy, v0, v1} !== {4'd0, 3'b100}) begin
      n_fail++; $display("FAIL flush_empty: cnt=%0d rdy=%b v=%b%b required 0 1 00", cnt, rdy, v0, v1);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 32'h13, 32'h13, 32'h3000, 1'b0, 1'b0); step();
    drive(2'b11, 32'h13, 32'h13, 32'h3008, 1'b0, 1'b0); step();
    drive(2'b11, 32'h13, 32'h13, 32'h3010, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1;
    mq.delete();
    n_checks++;
    if ({v0, v1, o_i0, o_i1, o_p0, o_p1, cnt, rdy} !== {2'b00, 128'd0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid: v=%b%b cnt=%0d rdy=%b pc0=%h required 00 0 1 0", v0, v1, cnt, rdy, o_p0);
    end
    @(negedge clk); rst = 1'b1;
    drive(2'b01, 32'h00500293, 0, 32'h500, 1'b0, 1'b0); step();
    drive(2'b00, 0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if ({v0, v1, o_p0, o_i0, cnt} !== {2'b10, 32'h500, 32'h00500293, 4'd1}) begin
      n_fail++; $display("FAIL reset_repush: v=%b%b pc=%h inst=%h cnt=%0d required 10 500 00500293 1", v0, v1, o_p0, o_i0, cnt);
    end
    idr = 1'b1; step();
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [7] = '{7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h23, 7'h03};
    return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'd0,
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 6)]};
  endfunction

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(2'($urandom), rnd_inst(), rnd_inst(),
            ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : {$urandom, 2'b00} >> 0,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
      predict();
      n_checks++;
      if ({rdy, v0, v1, o_i0, o_p0, o_i1, o_p1, cnt} !== {e_rdy, e_v0, e_v1, e_i0, e_p0, e_i1, e_p1, e_cnt}) begin
        n_fail++;
        $display("FAIL random[%0d]: got rdy=%b v=%b%b s0=%h@%h s1=%h@%h cnt=%0d required rdy=%b v=%b%b s0=%h@%h s1=%h@%h cnt=%0d",
                 k, rdy, v0, v1, o_i0, o_p0, o_i1, o_p1, cnt, e_rdy, e_v0, e_v1, e_i0, e_p0, e_i1, e_p1, e_cnt);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; fv = 0; i0 = 0; i1 = 0; pc = 0; flush = 0; idr = 0;
    @(negedge clk);
    test_reset();
    test_pair_issue();
    test_raw();
    test_branch();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
